// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// the NOP word presented when IF/ID is empty, opcode field location and the
// PC increment.
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_FULL    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int          OPCODE_MSB = 31;
  localparam int          OPCODE_LSB = 26;
  localparam int          OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int          PC_INC     = 4;

endpackage : fetch_pkg

// File: rtl/if_skid_buf.sv
// -----------------------------------------------------------------------------
// if_skid_buf
// One-entry {instr, pc} holding buffer used when a fetched word returns while
// decode is stalled on an occupied IF/ID register.
//
// Ports:
//   clk, rst_n          clock / asynchronous active-low reset (clears full)
//   load                capture d_instr/d_pc, mark full
//   unload              entry consumed, mark empty
//   clear               flush (redirect); wins over load/unload
//   d_instr, d_pc       word and its address to store
//   full                entry occupied
//   q_instr, q_pc       stored word and address
// -----------------------------------------------------------------------------
module if_skid_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              unload,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_instr,
  input  logic [ADDR_W-1:0] d_pc,
  output logic              full,
  output logic [DATA_W-1:0] q_instr,
  output logic [ADDR_W-1:0] q_pc
);

  logic              full_p0;
  logic [DATA_W-1:0] instr_p0;
  logic [ADDR_W-1:0] pc_p0;

  // Occupancy flag: the only state that matters after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_p0 <= 1'b0;
    end else if (clear) begin
      full_p0 <= 1'b0;
    end else if (load) begin
      full_p0 <= 1'b1;
    end else if (unload) begin
      full_p0 <= 1'b0;
    end
  end

  // Payload: only meaningful while full_p0 is set
  always_ff @(posedge clk) begin
    if (load && !clear) begin
      instr_p0 <= d_instr;
      pc_p0    <= d_pc;
    end
  end

  assign full    = full_p0;
  assign q_instr = instr_p0;
  assign q_pc    = pc_p0;

endmodule : if_skid_buf

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage plus IF/ID pipeline register. Keeps the PC, issues
// one outstanding req/ack read at a time, parks a returning word in a one-entry
// skid buffer when decode is stalled, and flushes everything on a redirect.
//
// Ports:
//   clk, rst_n                    clock / asynchronous active-low reset
//   imem_req, imem_addr           fetch request, held stable until imem_ack
//   imem_ack, imem_rdata          read completion and returned word
//   redirect_valid, redirect_pc   taken branch/jump and its target
//   stall                         decode cannot accept; IF/ID holds
//   if_valid, if_instr, if_pc,
//   if_pc_plus4, if_opcode        IF/ID contents presented to decode
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4,
  output logic [5:0]        if_opcode
);

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(PC_INC);
  endfunction

  fetch_state_e      state_p0, state_d;
  logic [ADDR_W-1:0] pc_p0, pc_d;
  logic [ADDR_W-1:0] discard_pc_p0;

  logic              vld_p1;
  logic [DATA_W-1:0] instr_p1;
  logic [ADDR_W-1:0] pc_p1;
  logic [ADDR_W-1:0] pc_plus4_p1;

  logic              ack_v;
  logic              ifid_open;
  logic              ifid_flush, ifid_from_mem, ifid_from_skid;
  logic              skid_load, skid_unload, skid_clear;
  logic              capture_discard;
  logic              skid_full;
  logic [DATA_W-1:0] skid_instr;
  logic [ADDR_W-1:0] skid_pc;

  // Stage 0: fetch control (PC, request FSM)

  // Request and address depend only on registered state, never on inputs.
  // In DISCARD the abandoned address is replayed until its ack drains.
  assign imem_req  = (state_p0 == ST_FETCH) || (state_p0 == ST_DISCARD);
  assign imem_addr = (state_p0 == ST_DISCARD) ? discard_pc_p0 : pc_p0;

  assign ack_v     = imem_ack && imem_req;
  assign ifid_open = !vld_p1 || !stall;

  always_comb begin
    state_d         = state_p0;
    pc_d            = pc_p0;
    skid_load       = 1'b0;
    skid_unload     = 1'b0;
    skid_clear      = 1'b0;
    ifid_flush      = 1'b0;
    ifid_from_mem   = 1'b0;
    ifid_from_skid  = 1'b0;
    capture_discard = 1'b0;
    case (state_p0)
      ST_IDLE: begin
        state_d = ST_FETCH;
        if (redirect_valid) pc_d = word_align(redirect_pc);
      end
      ST_FETCH: begin
        if (redirect_valid) begin
          pc_d       = word_align(redirect_pc);
          ifid_flush = 1'b1;
          skid_clear = 1'b1;
          // An ack in the same cycle retires the old request; the word is
          // dropped and fetching resumes at the target directly.
          if (!ack_v) begin
            state_d         = ST_DISCARD;
            capture_discard = 1'b1;
          end
        end else if (ack_v) begin
          pc_d = next_pc(pc_p0);
          if (ifid_open) begin
            ifid_from_mem = 1'b1;
          end else begin
            skid_load = 1'b1;
            state_d   = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (redirect_valid) begin
          pc_d       = word_align(redirect_pc);
          ifid_flush = 1'b1;
          skid_clear = 1'b1;
          state_d    = ST_FETCH;
        end else if (!stall) begin
          ifid_from_skid = 1'b1;
          skid_unload    = 1'b1;
          state_d        = ST_FETCH;
        end
      end
      ST_DISCARD: begin
        if (redirect_valid) begin
          pc_d       = word_align(redirect_pc);
          ifid_flush = 1'b1;
          skid_clear = 1'b1;
        end
        if (ack_v) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0      <= ST_IDLE;
      pc_p0         <= RESET_PC;
      discard_pc_p0 <= RESET_PC;
    end else begin
      state_p0 <= state_d;
      pc_p0    <= pc_d;
      if (capture_discard) discard_pc_p0 <= pc_p0;
    end
  end

  if_skid_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load),
    .unload  (skid_unload),
    .clear   (skid_clear),
    .d_instr (imem_rdata),
    .d_pc    (pc_p0),
    .full    (skid_full),
    .q_instr (skid_instr),
    .q_pc    (skid_pc)
  );

  // Stage 1: IF/ID register

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      instr_p1    <= DATA_W'(NOP_INSTR);
      pc_p1       <= '0;
      pc_plus4_p1 <= '0;
    end else if (ifid_flush) begin
      vld_p1   <= 1'b0;
      instr_p1 <= DATA_W'(NOP_INSTR);
    end else if (ifid_from_mem) begin
      vld_p1      <= 1'b1;
      instr_p1    <= imem_rdata;
      pc_p1       <= pc_p0;
      pc_plus4_p1 <= next_pc(pc_p0);
    end else if (ifid_from_skid && skid_full) begin
      vld_p1      <= 1'b1;
      instr_p1    <= skid_instr;
      pc_p1       <= skid_pc;
      pc_plus4_p1 <= next_pc(skid_pc);
    end else if (!stall) begin
      // Consumed by decode with nothing new arriving: present a NOP
      vld_p1   <= 1'b0;
      instr_p1 <= DATA_W'(NOP_INSTR);
    end
  end

  assign if_valid    = vld_p1;
  assign if_instr    = instr_p1;
  assign if_pc       = pc_p1;
  assign if_pc_plus4 = pc_plus4_p1;
  assign if_opcode   = instr_p1[DATA_W-1 -: OPCODE_W];

endmodule : fetch_stage
